// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin owner selection for a shared node-side WISHBONE
// bus. A grant lasts for the owner's whole CYC burst. A watchdog revokes a
// grant held too long and locks the offender out until it drops CYC. Every
// release is followed by one bus-turnaround cycle with no grant.
//
// Handshake: cyc_i[k] is master k's request and is sampled on every rising
// edge. gnt_o[k] is registered and means master k owns the bus in this cycle.
// A master keeps ownership while cyc_i[k] stays high. It releases the bus by
// dropping cyc_i[k]. The watchdog can also take the grant away. The arbiter
// never preempts an owner for another requester.
module wb_bus_arbiter #(
  parameter int N_MASTERS        = 4,
  parameter int N_BITS_MASTER_ID = 2,
  parameter int MAX_GRANT_CYCLES = 64,
  parameter int N_BITS_TIMER     = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        cyc_i,
  output logic [N_MASTERS-1:0]        gnt_o,
  output logic [N_BITS_MASTER_ID-1:0] gnt_id_o,
  output logic                        bus_busy_o,
  output logic                        timeout_o,
  output logic [N_BITS_MASTER_ID-1:0] timeout_id_o,
  output logic [1:0]                  state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam bit                         WATCHDOG_EN = (MAX_GRANT_CYCLES != 0);
  localparam logic [N_BITS_TIMER-1:0]    TIMER_LIMIT = N_BITS_TIMER'(MAX_GRANT_CYCLES);
  localparam logic [N_BITS_MASTER_ID-1:0] PTR_RESET  = N_BITS_MASTER_ID'(N_MASTERS - 1);

  // Wrap an offset from the round-robin pointer back into the master range.
  function automatic logic [N_BITS_MASTER_ID-1:0] wrap_idx(input int v);
    return N_BITS_MASTER_ID'(v % N_MASTERS);
  endfunction

  state_e                      state_q, state_d;
  logic [N_BITS_MASTER_ID-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_MASTERS-1:0]        lockout_q, lockout_d;
  logic [N_BITS_TIMER-1:0]     timer_q, timer_d;
  logic [N_MASTERS-1:0]        gnt_q, gnt_d;
  logic [N_BITS_MASTER_ID-1:0] gnt_id_q, gnt_id_d;
  logic                        busy_q, busy_d;
  logic                        timeout_q, timeout_d;
  logic [N_BITS_MASTER_ID-1:0] timeout_id_q, timeout_id_d;

  logic [N_MASTERS-1:0]        req_eff;
  logic                        win_found;
  logic [N_BITS_MASTER_ID-1:0] win_id;
  logic [N_BITS_MASTER_ID-1:0] cand;
  logic                        owner_cyc;
  logic                        timer_expired;

  assign req_eff       = cyc_i & ~lockout_q;
  assign owner_cyc     = cyc_i[gnt_id_q];
  assign timer_expired = WATCHDOG_EN && (timer_q == TIMER_LIMIT);

  // Scan eligible requests starting one past the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = wrap_idx(int'(rr_ptr_q) + i);
      if (!win_found && req_eff[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    timer_d      = timer_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    busy_d       = busy_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    // A locked master is forgiven as soon as it is seen with CYC low.
    lockout_d    = lockout_q & cyc_i;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d         = ST_GRANT;
          gnt_d           = '0;
          gnt_d[win_id]   = 1'b1;
          gnt_id_d        = win_id;
          busy_d          = 1'b1;
          rr_ptr_d        = win_id;
          timer_d         = N_BITS_TIMER'(1);
        end
      end

      ST_GRANT: begin
        if (!owner_cyc) begin
          // A drop on the expiry edge counts as a normal release.
          state_d = ST_RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          timer_d = '0;
        end else if (timer_expired) begin
          state_d             = ST_RELEASE;
          gnt_d               = '0;
          busy_d              = 1'b0;
          timer_d             = '0;
          timeout_d           = 1'b1;
          timeout_id_d        = gnt_id_q;
          lockout_d[gnt_id_q] = 1'b1;
        end else if (timer_q != '1) begin
          // Saturate rather than wrap when the watchdog is disabled.
          timer_d = timer_q + N_BITS_TIMER'(1);
        end
      end

      ST_RELEASE: begin
        // One turnaround cycle with the bus unowned.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  // All arbiter state and registered outputs; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= PTR_RESET;
      lockout_q    <= '0;
      timer_q      <= '0;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lockout_q    <= lockout_d;
      timer_q      <= timer_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign gnt_id_o     = gnt_id_q;
  assign bus_busy_o   = busy_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter. dut_a has an 8-cycle watchdog and dut_b has the
// watchdog disabled. A behavioural model of the arbitration rules predicts
// dut_a cycle by cycle.
module tb_wb_bus_arbiter;

  localparam int N     = 4;
  localparam int MAX_A = 8;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [N-1:0] cyc_a, gnt_a, cyc_b, gnt_b;
  logic [1:0]   gnt_id_a, to_id_a, st_a, gnt_id_b, to_id_b, st_b;
  logic         busy_a, to_a, busy_b, to_b;

  wb_bus_arbiter #(.N_MASTERS(4), .N_BITS_MASTER_ID(2), .MAX_GRANT_CYCLES(MAX_A),
                   .N_BITS_TIMER(4)) dut_a (
    .clk(clk), .rst(rst), .cyc_i(cyc_a), .gnt_o(gnt_a), .gnt_id_o(gnt_id_a),
    .bus_busy_o(busy_a), .timeout_o(to_a), .timeout_id_o(to_id_a), .state_dbg_o(st_a));

  wb_bus_arbiter #(.N_MASTERS(4), .N_BITS_MASTER_ID(2), .MAX_GRANT_CYCLES(0),
                   .N_BITS_TIMER(1)) dut_b (
    .clk(clk), .rst(rst), .cyc_i(cyc_b), .gnt_o(gnt_b), .gnt_id_o(gnt_id_b),
    .bus_busy_o(busy_b), .timeout_o(to_b), .timeout_id_o(to_id_b), .state_dbg_o(st_b));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model of dut_a ----------------
  int         m_owner;   // -1 when the bus is free
  int         m_held;    // cycles the current owner has held the grant
  int         m_last;    // last master granted
  bit         m_turn;    // bus is in its post-release turnaround cycle
  bit         m_lock[N];
  logic [N-1:0] e_gnt;
  logic         e_busy, e_to;
  logic [1:0]   e_id, e_to_id;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = N - 1; m_turn = 0;
    for (int k = 0; k < N; k++) m_lock[k] = 0;
    e_gnt = '0; e_busy = 0; e_to = 0; e_id = '0; e_to_id = '0;
  endtask

  task automatic model_step(input logic [N-1:0] cyc);
    bit old_lock[N];
    bit found;
    int c;
    for (int k = 0; k < N; k++) old_lock[k] = m_lock[k];
    for (int k = 0; k < N; k++) if (!cyc[k]) m_lock[k] = 0;
    e_to = 0;
    if (m_owner >= 0) begin
      if (!cyc[m_owner]) begin
        m_owner = -1; m_turn = 1;
      end else if (m_held == MAX_A) begin
        m_lock[m_owner] = 1; e_to = 1; e_to_id = 2'(m_owner);
        m_owner = -1; m_turn = 1;
      end else begin
        m_held++;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (!found && cyc[c] && !old_lock[c]) begin
          found = 1; m_owner = c; m_held = 1; m_last = c;
        end
      end
    end
    e_busy = (m_owner >= 0);
    e_gnt  = e_busy ? (N'(1) << m_owner) : '0;
    if (e_busy) e_id = 2'(m_owner);
  endtask

  // ---------------- driver: one clock with model check ----------------
  task automatic tick();
    @(posedge clk);
    model_step(cyc_a);
    @(negedge clk);
    n_tests++;
    if (gnt_a !== e_gnt) begin
      n_fail++; $display("FAIL model_gnt t=%0t got %b want %b", $time, gnt_a, e_gnt);
    end
    n_tests++;
    if (busy_a !== e_busy) begin
      n_fail++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy_a, e_busy);
    end
    n_tests++;
    if (to_a !== e_to) begin
      n_fail++; $display("FAIL model_timeout t=%0t got %b want %b", $time, to_a, e_to);
    end
    n_tests++;
    if (to_id_a !== e_to_id) begin
      n_fail++; $display("FAIL model_timeout_id t=%0t got %0d want %0d", $time, to_id_a, e_to_id);
    end
    if (e_busy) begin
      n_tests++;
      if (gnt_id_a !== e_id) begin
        n_fail++; $display("FAIL model_gnt_id t=%0t got %0d want %0d", $time, gnt_id_a, e_id);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc_a = '0; cyc_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; cyc_a = '0; cyc_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({gnt_a, gnt_id_a, busy_a, to_a, to_id_a, st_a} !== 13'd0) begin
      n_fail++; $display("FAIL reset_a got gnt=%b id=%0d busy=%b to=%b toid=%0d st=%0d want all 0",
                         gnt_a, gnt_id_a, busy_a, to_a, to_id_a, st_a);
    end
    n_tests++;
    if ({gnt_b, gnt_id_b, busy_b, to_b, to_id_b, st_b} !== 13'd0) begin
      n_fail++; $display("FAIL reset_b got gnt=%b id=%0d busy=%b to=%b toid=%0d st=%0d want all 0",
                         gnt_b, gnt_id_b, busy_b, to_b, to_id_b, st_b);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    tick(); tick();
    cyc_a = 4'b0001;
    tick();
    n_tests++;
    if (gnt_a !== 4'b0001 || gnt_id_a !== 2'd0 || busy_a !== 1'b1 || st_a !== S_GRANT) begin
      n_fail++; $display("FAIL basic_grant got gnt=%b id=%0d busy=%b st=%0d want 0001/0/1/%0d",
                         gnt_a, gnt_id_a, busy_a, st_a, S_GRANT);
    end
    repeat (6) tick();
    cyc_a = 4'b0000;
    tick();
    n_tests++;
    if (gnt_a !== 4'b0000 || busy_a !== 1'b0 || st_a !== S_RELEASE) begin
      n_fail++; $display("FAIL basic_release got gnt=%b busy=%b st=%0d want 0000/0/%0d",
                         gnt_a, busy_a, st_a, S_RELEASE);
    end
    tick();
    n_tests++;
    if (st_a !== S_IDLE) begin
      n_fail++; $display("FAIL basic_idle got st=%0d want %0d", st_a, S_IDLE);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_q[$];
    int run, gap, id, drop_k;
    bit first;
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    run = 0; gap = 0; drop_k = -1; first = 1; id = 0;
    cyc_a = 4'b1111;
    for (int cyc_n = 0; cyc_n < 60 && exp_q.size() > 0; cyc_n++) begin
      tick();
      if (drop_k >= 0) begin cyc_a[drop_k] = 1'b1; drop_k = -1; end
      if (gnt_a != '0) begin
        for (int k = 0; k < N; k++) if (gnt_a[k]) id = k;
        if (run == 0) begin
          n_tests++;
          if (2'(id) !== exp_q[0]) begin
            n_fail++; $display("FAIL rr_order got %0d want %0d", id, exp_q[0]);
          end
          void'(exp_q.pop_front());
          if (!first) begin
            n_tests++;
            if (gap != 2) begin
              n_fail++; $display("FAIL rr_gap got %0d want 2", gap);
            end
          end
          first = 0;
        end
        run++; gap = 0;
        if (run == 3) begin cyc_a[id] = 1'b0; drop_k = id; run = 0; end
      end else begin
        gap++;
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rr_incomplete got %0d grants pending want 0", exp_q.size());
    end
    cyc_a = '0;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int held, pulses, pulse_at, g1_at;
    logic [1:0] pid;
    do_reset();
    cyc_a = 4'b0100;
    tick();
    held = gnt_a[2] ? 1 : 0;
    cyc_a = 4'b0110;
    pulses = 0; pulse_at = -1; g1_at = -1; pid = '0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (gnt_a[2]) held++;
      if (to_a) begin pulses++; pulse_at = t; pid = to_id_a; end
      if (gnt_a == 4'b0010 && g1_at < 0) g1_at = t;
    end
    n_tests++;
    if (held != MAX_A) begin
      n_fail++; $display("FAIL to_hold got %0d want %0d", held, MAX_A);
    end
    n_tests++;
    if (pulses != 1 || pid !== 2'd2) begin
      n_fail++; $display("FAIL to_pulse got pulses=%0d id=%0d want 1/2", pulses, pid);
    end
    n_tests++;
    if (pulse_at < 0 || g1_at != pulse_at + 2) begin
      n_fail++; $display("FAIL to_next_grant got %0d want %0d", g1_at, pulse_at + 2);
    end
    // master 1 releases; master 2 still requests but is locked out
    cyc_a = 4'b0100;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (t >= 1) begin
        n_tests++;
        if (gnt_a !== 4'b0000) begin
          n_fail++; $display("FAIL lockout_hold got %b want 0000", gnt_a);
        end
      end
    end
    cyc_a = 4'b0000;
    tick();
    cyc_a = 4'b0100;
    tick();
    n_tests++;
    if (gnt_a !== 4'b0100) begin
      n_fail++; $display("FAIL lockout_clear got %b want 0100", gnt_a);
    end
    cyc_a = '0;
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc_a = 4'b0001;
    repeat (MAX_A) tick();
    cyc_a = 4'b0000;
    tick();
    n_tests++;
    if (to_a !== 1'b0 || gnt_a !== 4'b0000) begin
      n_fail++; $display("FAIL simul_drop got to=%b gnt=%b want 0/0000", to_a, gnt_a);
    end
    tick(); tick();
    cyc_a = 4'b0001;
    tick();
    n_tests++;
    if (gnt_a !== 4'b0001) begin
      n_fail++; $display("FAIL simul_regrant got %b want 0001", gnt_a);
    end
    cyc_a = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc_a = 4'b0100;
    tick(); tick();
    n_tests++;
    if (gnt_a !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_pre got %b want 0100", gnt_a);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (gnt_a !== 4'b0000 || busy_a !== 1'b0 || to_a !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got gnt=%b busy=%b to=%b want 0000/0/0", gnt_a, busy_a, to_a);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    cyc_a = 4'b1100;
    rst = 1'b1;
    tick();
    n_tests++;
    if (gnt_a !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_first got %b want 0100", gnt_a);
    end
    cyc_a = '0;
    repeat (3) tick();
  endtask

  task automatic test_no_watchdog();
    cyc_b = 4'b0001;
    @(posedge clk); @(negedge clk);
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (gnt_b !== 4'b0001 || to_b !== 1'b0) begin
        n_fail++; $display("FAIL nowd_hold cycle %0d got gnt=%b to=%b want 0001/0", t, gnt_b, to_b);
      end
    end
    cyc_b = '0;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (gnt_b !== 4'b0000) begin
      n_fail++; $display("FAIL nowd_release got %b want 0000", gnt_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 15) == 0) cyc_a[k] = ~cyc_a[k];
      tick();
    end
    cyc_a = '0;
    repeat (3) tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0; cyc_a = '0; cyc_b = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_no_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
